lsu_seq: RTL and testbench
==========================

Name: lsu_seq

Overview:
- Multi-cycle load/store sequencer between the control unit's memory controls (memrw, memword, funct3 unsigned bit) and a handshaked data-memory port.
- Aligns byte and halfword accesses onto a 32-bit word bus.
- Stalls the core until the access completes, then delivers a sign- or zero-extended load result for the writeback mux.
- Flags misaligned or illegal accesses and bus timeouts instead of issuing them.

Parameters:
- TIMEOUT, 255, cycles to wait for dmem_ack in BUSY before aborting; legal range 1..65535.
- CW, 16, width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  load/store instruction valid in execute; sampled only in IDLE.
- memrw  in  1  1 = store, 0 = load.
- memword  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- uns  in  1  load zero-extend when 1 (funct3 bit 2); ignored for stores.
- addr  in  32  ALU effective address.
- wdata  in  32  store data (rs2).
- stall  out  1  hold PC and pipeline registers.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result, valid while done = 1.
- misalign  out  1  with done: access rejected (misaligned or memword = 3).
- timeout  out  1  with done: bus did not respond.
- dmem_req  out  1  bus request, held until ack or abort.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word address; {addr[31:2], 2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  bus completion; read data valid in the same cycle.
- dmem_rdata  in  32  bus read word.

Behaviour:
- Reset value of every output, state and counter is 0; state = IDLE.
- A reset asserted mid-access drops dmem_req at that edge. A late dmem_ack is then ignored.
- States: IDLE, BUSY, DONE.
- IDLE, start = 0: stays in IDLE.
- IDLE, start = 1, access illegal: goes to DONE with misalign = 1. No bus cycle is issued.
  - Illegal means: memword = 3; or half with addr[0] = 1; or word with addr[1:0] != 0.
- IDLE, start = 1, access legal: goes to BUSY. On that edge it registers dmem_addr, dmem_be, dmem_wdata, dmem_we = memrw, dmem_req = 1, and the load-side controls (addr[1:0], memword, uns). The counter clears.
- BUSY, dmem_ack = 1: goes to DONE and drops dmem_req. For loads, registers the extended result into rdata.
- BUSY, no ack: the counter increments. When counter = TIMEOUT-1 with no ack, goes to DONE with timeout = 1 and drops dmem_req.
- DONE: done = 1 for exactly one cycle, then goes to IDLE. Flags clear when leaving DONE.
- rdata:
  - Holds its value outside DONE.
  - Is 0 for stores and for rejected accesses.
- stall is combinational: (state == IDLE && start) || state == BUSY.
  - stall = 0 in DONE, so the pipeline advances exactly on the done cycle.
- start in BUSY or DONE is ignored. The core is stalled then, so any start seen is spurious.
- Minimum latency, start to done: 2 cycles (ack in first BUSY cycle).
- Store byte: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
- Store half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
- Store word: be = 4'b1111; wdata passed through.
- Loads drive be = 4'b1111.
- Load byte: selects dmem_rdata[8*a+7 : 8*a], a = addr[1:0]. Sign-extends bit 7, or zero-extends when uns = 1.
- Load half: selects the upper half if addr[1] = 1, else the lower half. Sign/zero-extends from bit 15.
- Load word: passes dmem_rdata through; uns ignored.
- dmem_addr, dmem_be, dmem_wdata and dmem_we stay stable while dmem_req = 1.

Test Plan:
- Word store: start, memrw = 1, memword = 2, addr = 0x100, wdata = 0xDEADBEEF, ack on 3rd BUSY cycle → dmem_addr = 0x100, be = 0xF, req high 3 cycles, stall high 4 cycles, done pulse, misalign = 0.
- Byte load, signed: addr = 0x203, dmem_rdata = 0x80FF_1234, uns = 0, immediate ack → rdata = 0xFFFFFF80, done 2 cycles after start. With uns = 1 → rdata = 0x00000080.
- Half store, upper: addr = 0x06, wdata = 0x0000ABCD → dmem_addr = 0x04, be = 0xC, dmem_wdata = 0xABCDABCD.
- Misaligned/illegal: word load at addr = 0x102 → no dmem_req ever, done + misalign next cycle, rdata = 0. Repeat with half at odd addr and with memword = 3.
- Timeout: TIMEOUT = 4, ack never asserted → req high exactly 4 cycles, then done + timeout = 1, stall drops. A late ack is ignored and the FSM stays in IDLE.
- Reset mid-BUSY: rst pulsed during BUSY → next cycle req = 0, stall = 0, done = 0, state IDLE. A subsequent start completes normally.

Source files
------------

// File: rtl/lsu_seq.sv
// lsu_seq: multi-cycle load/store sequencer that aligns byte/half/word accesses
// onto a handshaked 32-bit data bus and stalls the core until completion.
module lsu_seq #(
   parameter int TIMEOUT = 255,
   parameter int CW = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        memrw,
   input  logic [1:0]  memword,
   input  logic        uns,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        timeout,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata
);
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
   logic [1:0] state;
   logic [CW-1:0] cnt;
   logic [1:0] lo, mw;
   logic us, illegal;
   logic [3:0] be_n;
   logic [31:0] wd_n, sh, ld;
   logic [7:0] lb;
   logic [15:0] lh;
   assign illegal = memword == 2'd3 || (memword == 2'd1 && addr[0]) || (memword == 2'd2 && addr[1:0] != 2'b00);
   assign stall = (state == IDLE && start) || state == BUSY;
   assign done = state == DONE;
   always_comb begin
      be_n = !memrw ? 4'hF : memword == 2'd0 ? 4'b0001 << addr[1:0] : memword == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'hF;
      wd_n = memword == 2'd0 ? {4{wdata[7:0]}} : memword == 2'd1 ? {2{wdata[15:0]}} : wdata;
      sh = dmem_rdata >> {lo, 3'b000};
      lb = sh[7:0];
      lh = lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      ld = mw == 2'd0 ? {{24{lb[7] & ~us}}, lb} : mw == 2'd1 ? {{16{lh[15] & ~us}}, lh} : dmem_rdata;
   end
   // load-side controls are latched at issue so the core may change its inputs while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         rdata <= '0;
         misalign <= 1'b0;
         timeout <= 1'b0;
         dmem_req <= 1'b0;
         dmem_we <= 1'b0;
         dmem_addr <= '0;
         dmem_be <= '0;
         dmem_wdata <= '0;
         lo <= '0;
         mw <= '0;
         us <= 1'b0;
      end else if (state == IDLE) begin
         if (start && illegal) begin
            state <= DONE;
            misalign <= 1'b1;
            rdata <= '0;
         end else if (start) begin
            state <= BUSY;
            cnt <= '0;
            dmem_req <= 1'b1;
            dmem_we <= memrw;
            dmem_addr <= {addr[31:2], 2'b00};
            dmem_be <= be_n;
            dmem_wdata <= wd_n;
            lo <= addr[1:0];
            mw <= memword;
            us <= uns;
         end
      end else if (state == BUSY) begin
         if (dmem_ack) begin
            state <= DONE;
            dmem_req <= 1'b0;
            rdata <= dmem_we ? '0 : ld;
         end else if (cnt == CW'(TIMEOUT - 1)) begin
            state <= DONE;
            dmem_req <= 1'b0;
            timeout <= 1'b1;
            rdata <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         state <= IDLE;
         misalign <= 1'b0;
         timeout <= 1'b0;
      end
   end
endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: scoreboard-driven bench for lsu_seq; completions are matched
// against expectations queued when each access is launched.
module tb_lsu_seq;
   logic clk = 1'b0;
   logic rst = 1'b1, start = 1'b0, memrw = 1'b0, uns = 1'b0, dmem_ack = 1'b0;
   logic [1:0] memword = 2'd0;
   logic [31:0] addr = '0, wdata = '0, dmem_rdata = '0;
   logic stall, done, misalign, timeout, dmem_req, dmem_we;
   logic [31:0] rdata, dmem_addr, dmem_wdata;
   logic [3:0] dmem_be;
   int n_chk = 0, n_fail = 0;
   typedef struct packed { logic [31:0] rd; logic mis; logic tmo; logic chk_rd; } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   lsu_seq #(.TIMEOUT(4), .CW(16)) dut (
      .clk(clk), .rst(rst), .start(start), .memrw(memrw), .memword(memword), .uns(uns),
      .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
      .misalign(misalign), .timeout(timeout), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ack_at: index of the BUSY cycle that sees dmem_ack, or -1 for never
   task automatic access(input logic rw, input logic [1:0] mw, input logic u, input logic [31:0] a,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] rd,
                         output int nreq, output int nstall, output int lat);
      exp_t e, g;
      logic ill;
      logic [7:0] bv;
      logic [15:0] hv;
      logic [31:0] ext, x_wd;
      logic [3:0] x_be;
      int k;
      k = int'(a[1:0]);
      ill = mw == 2'd3 || (mw == 2'd1 && a[0]) || (mw == 2'd2 && a[1:0] != 2'b00);
      bv = rd[8*k +: 8];
      hv = a[1] ? rd[31:16] : rd[15:0];
      ext = mw == 2'd0 ? (u ? {24'b0, bv} : {{24{bv[7]}}, bv}) : mw == 2'd1 ? (u ? {16'b0, hv} : {{16{hv[15]}}, hv}) : rd;
      x_be = !rw ? 4'hF : mw == 2'd0 ? (k == 0 ? 4'h1 : k == 1 ? 4'h2 : k == 2 ? 4'h4 : 4'h8) : mw == 2'd1 ? (a[1] ? 4'hC : 4'h3) : 4'hF;
      x_wd = mw == 2'd0 ? {wd[7:0], wd[7:0], wd[7:0], wd[7:0]} : mw == 2'd1 ? {wd[15:0], wd[15:0]} : wd;
      e.rd = (ill || rw || ack_at < 0) ? 32'h0 : ext;
      e.mis = ill;
      e.tmo = !ill && ack_at < 0;
      e.chk_rd = !e.tmo;
      sb.push_back(e);
      nreq = 0; nstall = 0; lat = -1;
      start = 1'b1; memrw = rw; memword = mw; uns = u; addr = a; wdata = wd; dmem_rdata = rd;
      for (int c = 0; c < 40 && lat < 0; c++) begin
         #1;
         if (stall) nstall++;
         if (dmem_req) begin
            n_chk += 3;
            if (dmem_addr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL bus_addr got %h exp %h", dmem_addr, {a[31:2], 2'b00}); end
            if (dmem_be !== x_be) begin n_fail++; $display("FAIL bus_be got %h exp %h", dmem_be, x_be); end
            if (dmem_we !== rw) begin n_fail++; $display("FAIL bus_we got %b exp %b", dmem_we, rw); end
            if (rw) begin
               n_chk++;
               if (dmem_wdata !== x_wd) begin n_fail++; $display("FAIL bus_wdata got %h exp %h", dmem_wdata, x_wd); end
            end
            dmem_ack = (nreq == ack_at);
            nreq++;
         end else dmem_ack = 1'b0;
         if (done) begin
            lat = c;
            n_chk += 4;
            if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_in_done got %b exp 0", stall); end
            if (sb.size() == 0) begin n_fail++; $display("FAIL sb_empty got done with no expectation queued"); end
            else begin
               g = sb.pop_front();
               if (g.chk_rd && rdata !== g.rd) begin n_fail++; $display("FAIL rdata got %h exp %h", rdata, g.rd); end
               if (misalign !== g.mis) begin n_fail++; $display("FAIL misalign got %b exp %b", misalign, g.mis); end
               if (timeout !== g.tmo) begin n_fail++; $display("FAIL timeout got %b exp %b", timeout, g.tmo); end
            end
         end
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      dmem_ack = 1'b0;
      if (lat < 0) begin n_chk++; n_fail++; $display("FAIL done_wait got no done within 40 cycles"); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(); cyc();
      n_chk++;
      if ({stall, done, misalign, timeout, dmem_req, dmem_we, rdata, dmem_addr, dmem_be, dmem_wdata} !== '0) begin
         n_fail++; $display("FAIL reset_outputs got nonzero req=%b done=%b rdata=%h", dmem_req, done, rdata);
      end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_word_store();
      int nr, ns, lt;
      access(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 2, 32'h0, nr, ns, lt);
      n_chk += 3;
      if (nr !== 3) begin n_fail++; $display("FAIL ws_req_cycles got %0d exp 3", nr); end
      if (ns !== 4) begin n_fail++; $display("FAIL ws_stall_cycles got %0d exp 4", ns); end
      if (lt !== 4) begin n_fail++; $display("FAIL ws_latency got %0d exp 4", lt); end
   endtask

   task automatic test_loads();
      int nr, ns, lt;
      access(1'b0, 2'd0, 1'b0, 32'h203, 32'h80FF1234, 0, 32'h80FF1234, nr, ns, lt);
      n_chk += 2;
      if (lt !== 2) begin n_fail++; $display("FAIL lb_latency got %0d exp 2", lt); end
      if (rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_signed_hold got %h exp ffffff80", rdata); end
      access(1'b0, 2'd0, 1'b1, 32'h203, 32'h80FF1234, 0, 32'h80FF1234, nr, ns, lt);
      n_chk++;
      if (rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu_hold got %h exp 00000080", rdata); end
      access(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1, 32'h9ABC0000, nr, ns, lt);
      n_chk++;
      if (rdata !== 32'hFFFF9ABC) begin n_fail++; $display("FAIL lh_upper got %h exp ffff9abc", rdata); end
      access(1'b0, 2'd2, 1'b1, 32'h40, 32'h0, 0, 32'h87654321, nr, ns, lt);
      n_chk++;
      if (rdata !== 32'h87654321) begin n_fail++; $display("FAIL lw got %h exp 87654321", rdata); end
   endtask

   task automatic test_stores();
      int nr, ns, lt;
      access(1'b1, 2'd1, 1'b0, 32'h06, 32'h0000ABCD, 0, 32'hFFFFFFFF, nr, ns, lt);
      n_chk += 2;
      if (nr !== 1) begin n_fail++; $display("FAIL sh_req_cycles got %0d exp 1", nr); end
      if (rdata !== 32'h0) begin n_fail++; $display("FAIL sh_rdata got %h exp 0", rdata); end
      access(1'b1, 2'd0, 1'b0, 32'h01, 32'h12345655, 0, 32'h0, nr, ns, lt);
   endtask

   task automatic test_misalign();
      int nr, ns, lt;
      logic [1:0] mws[3] = '{2'd2, 2'd1, 2'd3};
      logic [31:0] as[3] = '{32'h102, 32'h101, 32'h100};
      for (int i = 0; i < 3; i++) begin
         access(1'b0, mws[i], 1'b0, as[i], 32'h0, 0, 32'hFFFFFFFF, nr, ns, lt);
         n_chk += 3;
         if (nr !== 0) begin n_fail++; $display("FAIL mis_req[%0d] got %0d exp 0", i, nr); end
         if (lt !== 1) begin n_fail++; $display("FAIL mis_latency[%0d] got %0d exp 1", i, lt); end
         if (rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rdata[%0d] got %h exp 0", i, rdata); end
      end
   endtask

   task automatic test_timeout();
      int nr, ns, lt;
      access(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, -1, 32'h11111111, nr, ns, lt);
      n_chk += 3;
      if (nr !== 4) begin n_fail++; $display("FAIL to_req_cycles got %0d exp 4", nr); end
      if (ns !== 5) begin n_fail++; $display("FAIL to_stall_cycles got %0d exp 5", ns); end
      if (lt !== 5) begin n_fail++; $display("FAIL to_latency got %0d exp 5", lt); end
      dmem_ack = 1'b1;
      cyc();
      dmem_ack = 1'b0;
      #1;
      n_chk++;
      if ({dmem_req, done, stall, timeout} !== 4'b0) begin
         n_fail++; $display("FAIL to_late_ack got req=%b done=%b stall=%b exp all 0", dmem_req, done, stall);
      end
      cyc();
   endtask

   task automatic test_reset_busy();
      int nr, ns, lt;
      start = 1'b1; memrw = 1'b0; memword = 2'd2; addr = 32'h20;
      cyc();
      start = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      n_chk++;
      if ({dmem_req, stall, done} !== 3'b0) begin
         n_fail++; $display("FAIL rb_after_reset got req=%b stall=%b done=%b exp 0", dmem_req, stall, done);
      end
      dmem_ack = 1'b1;
      cyc();
      dmem_ack = 1'b0;
      n_chk++;
      if ({dmem_req, done} !== 2'b0) begin n_fail++; $display("FAIL rb_late_ack got req=%b done=%b exp 0", dmem_req, done); end
      access(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0, 32'hBEEF0000, nr, ns, lt);
      n_chk++;
      if (lt !== 2) begin n_fail++; $display("FAIL rb_resume_latency got %0d exp 2", lt); end
   endtask

   task automatic test_back_to_back();
      int nr, ns, lt;
      for (int i = 0; i < 20; i++) begin
         access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, int'($urandom_range(0, 2)), $urandom, nr, ns, lt);
      end
   endtask

   initial begin
      test_reset();
      test_word_store();
      test_loads();
      test_stores();
      test_misalign();
      test_timeout();
      test_reset_busy();
      test_back_to_back();
      n_chk++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover got %0d entries exp 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
